countdown_timer: RTL and testbench

BCD countdown timer, the down-counting counterpart of the team's stopwatch: loaded with a minutes/seconds preset, it decrements a six-digit BCD time value on each 1 ms timebase tick and flags expiry at 0:00.000. It sits between the front-panel controls (load/start/stop) and the same display path that consumes stopwatch digits, and presents digits with identical weights (min, tens-of-s, units-of-s, 100 ms, 10 ms, 1 ms).

---
 rtl/countdown_timer.sv | 185 ++++++++++++++++++
 tb/tb_countdown_timer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: six-digit BCD countdown (M:SS.mmm) decremented on a 1 ms tick, flags expiry at zero.
//
// Optional feature macro: COUNTDOWN_ALARM_EN (blinking alarm in DONE; alarm_o tied low when undefined).
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset (clears to IDLE, all outputs 0)
//   tick_i         1 ms timebase, single-cycle pulse
//   load_i         capture preset (ignored while running)
//   preset_min_i   minutes preset, BCD, clamped to MAX_MIN
//   preset_seg2_i  tens-of-seconds preset, BCD, clamped to 5
//   preset_seg1_i  units-of-seconds preset, BCD, clamped to 9
//   start_i        begin/resume counting (pulse)
//   stop_i         pause counting (pulse), wins over start_i
//   min_o..milli_o current time digits, BCD, same weights as the stopwatch
//   running_o      high while counting
//   done_o         high once zero has been reached, until load or reset
//   expired_o      single-cycle pulse on the cycle done_o first rises
//   alarm_o        2 Hz blink while done (COUNTDOWN_ALARM_EN only)
module countdown_timer #(
    parameter int MAX_MIN = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_i,
    input  logic       load_i,
    input  logic [3:0] preset_min_i,
    input  logic [3:0] preset_seg2_i,
    input  logic [3:0] preset_seg1_i,
    input  logic       start_i,
    input  logic       stop_i,
    output logic [3:0] min_o,
    output logic [3:0] seg2_o,
    output logic [3:0] seg1_o,
    output logic [3:0] deci_o,
    output logic [3:0] centi_o,
    output logic [3:0] milli_o,
    output logic       running_o,
    output logic       done_o,
    output logic       expired_o,
    output logic       alarm_o
);
    localparam logic [3:0] MAX_BCD = 4'(MAX_MIN);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] min_q, seg2_q, seg1_q, deci_q, centi_q, milli_q;
    logic [3:0] min_d, seg2_d, seg1_d, deci_d, centi_d, milli_d;
    logic       expired_q, expired_d;

    logic [3:0] dec_min, dec_seg2, dec_seg1, dec_deci, dec_centi, dec_milli;
    logic       b_centi, b_deci, b_seg1, b_seg2, b_min;
    logic       is_zero, dec_zero;
    logic [3:0] ld_min, ld_seg2, ld_seg1;

    // Borrow ripples upward; each digit wraps to its own maximum when borrowed from at 0.
    // The minutes digit never borrows from zero because RUN is never entered at 0:00.000.
    assign dec_milli = (milli_q == 4'd0) ? 4'd9 : milli_q - 4'd1;
    assign b_centi   = (milli_q == 4'd0);
    assign dec_centi = b_centi ? ((centi_q == 4'd0) ? 4'd9 : centi_q - 4'd1) : centi_q;
    assign b_deci    = b_centi && (centi_q == 4'd0);
    assign dec_deci  = b_deci ? ((deci_q == 4'd0) ? 4'd9 : deci_q - 4'd1) : deci_q;
    assign b_seg1    = b_deci && (deci_q == 4'd0);
    assign dec_seg1  = b_seg1 ? ((seg1_q == 4'd0) ? 4'd9 : seg1_q - 4'd1) : seg1_q;
    assign b_seg2    = b_seg1 && (seg1_q == 4'd0);
    assign dec_seg2  = b_seg2 ? ((seg2_q == 4'd0) ? 4'd5 : seg2_q - 4'd1) : seg2_q;
    assign b_min     = b_seg2 && (seg2_q == 4'd0);
    assign dec_min   = b_min ? min_q - 4'd1 : min_q;

    assign is_zero  = ~|{min_q, seg2_q, seg1_q, deci_q, centi_q, milli_q};
    assign dec_zero = ~|{dec_min, dec_seg2, dec_seg1, dec_deci, dec_centi, dec_milli};

    assign ld_min  = (preset_min_i  > MAX_BCD) ? MAX_BCD : preset_min_i;
    assign ld_seg2 = (preset_seg2_i > 4'd5)    ? 4'd5    : preset_seg2_i;
    assign ld_seg1 = (preset_seg1_i > 4'd9)    ? 4'd9    : preset_seg1_i;

`ifdef COUNTDOWN_ALARM_EN
    logic [7:0] acnt_q, acnt_d;
    logic       alarm_q, alarm_d;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            min_q     <= 4'd0;
            seg2_q    <= 4'd0;
            seg1_q    <= 4'd0;
            deci_q    <= 4'd0;
            centi_q   <= 4'd0;
            milli_q   <= 4'd0;
            expired_q <= 1'b0;
`ifdef COUNTDOWN_ALARM_EN
            acnt_q    <= 8'd0;
            alarm_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            seg2_q    <= seg2_d;
            seg1_q    <= seg1_d;
            deci_q    <= deci_d;
            centi_q   <= centi_d;
            milli_q   <= milli_d;
            expired_q <= expired_d;
`ifdef COUNTDOWN_ALARM_EN
            acnt_q    <= acnt_d;
            alarm_q   <= alarm_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        seg2_d    = seg2_q;
        seg1_d    = seg1_q;
        deci_d    = deci_q;
        centi_d   = centi_q;
        milli_d   = milli_q;
        expired_d = 1'b0;
        case (state_q)
            RUN: begin
                if (tick_i) begin
                    {min_d, seg2_d, seg1_d, deci_d, centi_d, milli_d} =
                        {dec_min, dec_seg2, dec_seg1, dec_deci, dec_centi, dec_milli};
                    if (dec_zero) begin
                        state_d   = DONE;
                        expired_d = 1'b1;
                    end
                end
                // Reaching zero takes precedence over a concurrent stop.
                if (stop_i && state_d == RUN)
                    state_d = PAUSED;
            end
            default: begin
                if (load_i) begin
                    {min_d, seg2_d, seg1_d} = {ld_min, ld_seg2, ld_seg1};
                    {deci_d, centi_d, milli_d} = 12'd0;
                    state_d = IDLE;
                end else if (start_i && !stop_i && state_q != DONE && !is_zero) begin
                    state_d = RUN;
                end
            end
        endcase
    end

`ifdef COUNTDOWN_ALARM_EN
    // Blink counter: restarts on DONE entry, toggles the alarm every 250th tick while in DONE.
    always_comb begin
        acnt_d  = acnt_q;
        alarm_d = alarm_q;
        if (state_d != DONE) begin
            acnt_d  = 8'd0;
            alarm_d = 1'b0;
        end else if (state_q != DONE) begin
            acnt_d  = 8'd0;
            alarm_d = 1'b1;
        end else if (tick_i) begin
            acnt_d  = (acnt_q == 8'd249) ? 8'd0 : acnt_q + 8'd1;
            alarm_d = (acnt_q == 8'd249) ? ~alarm_q : alarm_q;
        end
    end
`endif

    // Output logic
    always_comb begin
        min_o     = min_q;
        seg2_o    = seg2_q;
        seg1_o    = seg1_q;
        deci_o    = deci_q;
        centi_o   = centi_q;
        milli_o   = milli_q;
        running_o = (state_q == RUN);
        done_o    = (state_q == DONE);
        expired_o = expired_q;
`ifdef COUNTDOWN_ALARM_EN
        alarm_o   = alarm_q;
`else
        alarm_o   = 1'b0;
`endif
    end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed checks of countdown_timer against a millisecond-count reference model.
module tb_countdown_timer;
    localparam int MAX_MIN = 9;
`ifdef COUNTDOWN_ALARM_EN
    localparam bit ALARM_ON = 1'b1;
`else
    localparam bit ALARM_ON = 1'b0;
`endif
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;

    logic       clk = 1'b0, reset = 1'b1;
    logic       tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
    logic [3:0] p_min = 4'd0, p_seg2 = 4'd0, p_seg1 = 4'd0;
    logic [3:0] min, seg2, seg1, deci, centi, milli;
    logic       running, done, expired, alarm;

    int n_cmp = 0, n_bad = 0;
    bit chk_on = 1'b0;

    countdown_timer #(.MAX_MIN(MAX_MIN)) dut (
        .clk(clk), .reset(reset), .tick_i(tick), .load_i(load),
        .preset_min_i(p_min), .preset_seg2_i(p_seg2), .preset_seg1_i(p_seg1),
        .start_i(start), .stop_i(stop),
        .min_o(min), .seg2_o(seg2), .seg1_o(seg1), .deci_o(deci), .centi_o(centi), .milli_o(milli),
        .running_o(running), .done_o(done), .expired_o(expired), .alarm_o(alarm)
    );

    always #5 clk = ~clk;

    wire [23:0] digs = {min, seg2, seg1, deci, centi, milli};

    // Reference model: remaining time as a plain millisecond count.
    int m_ms = 0, m_st = S_IDLE, m_acnt = 0;
    bit m_exp = 1'b0, m_alarm = 1'b0;

    function automatic int clampv(logic [3:0] v, int lim);
        return (int'(v) > lim) ? lim : int'(v);
    endfunction

    function automatic logic [23:0] to_bcd(int ms);
        int s = ms / 1000;
        return {4'(ms / 60000), 4'((s % 60) / 10), 4'(s % 10), 4'((ms / 100) % 10), 4'((ms / 10) % 10), 4'(ms % 10)};
    endfunction

    always @(posedge clk or posedge reset) begin
        int prev;
        if (reset) begin
            m_ms = 0; m_st = S_IDLE; m_exp = 1'b0; m_alarm = 1'b0; m_acnt = 0;
        end else begin
            prev  = m_st;
            m_exp = 1'b0;
            if (m_st == S_RUN) begin
                if (tick) begin
                    m_ms = m_ms - 1;
                    if (m_ms == 0) begin m_st = S_DONE; m_exp = 1'b1; end
                end
                if (stop && m_st == S_RUN) m_st = S_PAUSED;
            end else if (load) begin
                m_ms = clampv(p_min, MAX_MIN) * 60000 + clampv(p_seg2, 5) * 10000 + clampv(p_seg1, 9) * 1000;
                m_st = S_IDLE;
            end else if (start && !stop && m_st != S_DONE && m_ms != 0) begin
                m_st = S_RUN;
            end
            if (!ALARM_ON || m_st != S_DONE) begin
                m_alarm = 1'b0; m_acnt = 0;
            end else if (prev != S_DONE) begin
                m_alarm = 1'b1; m_acnt = 0;
            end else if (tick) begin
                m_acnt = m_acnt + 1;
                if (m_acnt == 250) begin m_acnt = 0; m_alarm = ~m_alarm; end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [27:0] act, exp_v;
        if (chk_on) begin
            act   = {digs, running, done, expired, alarm};
            exp_v = {to_bcd(m_ms), m_st == S_RUN, m_st == S_DONE, m_exp, m_alarm};
            n_cmp++;
            if (act !== exp_v) begin
                n_bad++;
                if (n_bad < 20) $display("FAIL model_cycle t=%0t dut=%h model=%h", $time, act, exp_v);
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic do_load(logic [3:0] m, logic [3:0] s2, logic [3:0] s1);
        p_min = m; p_seg2 = s2; p_seg1 = s1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; @(negedge clk); stop = 1'b0;
    endtask

    task automatic run_ticks(int n);
        tick = 1'b1;
        repeat (n) @(negedge clk);
        tick = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_state", {digs, running, done, expired, alarm}, 32'd0);
        reset = 1'b0;
        chk_on = 1'b1;

        // Clamping and start-at-zero
        do_load(4'hF, 4'h7, 4'hC);
        chk("clamp", digs, 24'h959000);
        do_load(4'd0, 4'd0, 4'd0);
        pulse_start();
        chk("zero_start_running", running, 0);
        chk("zero_start_done", done, 0);

        // load and start together: load wins, stays IDLE
        p_min = 4'd0; p_seg2 = 4'd0; p_seg1 = 4'd4; load = 1'b1; start = 1'b1;
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        chk("load_start_digs", digs, 24'h004000);
        chk("load_start_running", running, 0);

        // Borrow chain
        do_load(4'd0, 4'd1, 4'd0);
        pulse_start();
        chk("start_running", running, 1);
        run_ticks(1);
        chk("borrow_first", digs, 24'h009999);
        run_ticks(1000);
        chk("borrow_1000", digs, 24'h008999);
        pulse_stop();
        chk("stop_running", running, 0);

        // Pause with concurrent tick, ignored ticks, resume
        do_load(4'd0, 4'd0, 4'd5);
        chk("load_paused", digs, 24'h005000);
        pulse_start();
        run_ticks(1200);
        chk("run_1200", digs, 24'h003800);
        tick = 1'b1; stop = 1'b1;
        @(negedge clk);
        tick = 1'b0; stop = 1'b0;
        chk("stop_tick_digs", digs, 24'h003799);
        chk("stop_tick_running", running, 0);
        run_ticks(500);
        chk("paused_ticks", digs, 24'h003799);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("start_stop_paused", running, 0);
        pulse_start();
        chk("resume_running", running, 1);
        chk("resume_digs", digs, 24'h003799);
        run_ticks(1);
        chk("resume_tick", digs, 24'h003798);

        // Load ignored in RUN, then asynchronous reset mid-run
        pulse_stop();
        do_load(4'd0, 4'd0, 4'd2);
        pulse_start();
        do_load(4'd0, 4'd0, 4'd5);
        chk("load_in_run", digs, 24'h002000);
        run_ticks(3);
        chk("run_3", digs, 24'h001997);
        #2 reset = 1'b1;
        #1 chk("async_reset", {digs, running, done, expired, alarm}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Full 1:23 countdown to expiry, then alarm blink
        do_load(4'd1, 4'd2, 4'd3);
        pulse_start();
        run_ticks(82999);
        chk("last_ms", digs, 24'h000001);
        chk("last_ms_running", running, 1);
        run_ticks(1);
        chk("expiry_digs", digs, 24'h000000);
        chk("expiry_pulse", expired, 1);
        chk("expiry_done", done, 1);
        chk("expiry_running", running, 0);
        chk("alarm_entry", alarm, 32'(ALARM_ON));
        run_ticks(1);
        chk("expired_once", expired, 0);
        chk("done_hold", {digs, done}, 25'h1);
        run_ticks(248);
        chk("alarm_249", alarm, 32'(ALARM_ON));
        run_ticks(1);
        chk("alarm_250", alarm, 0);
        run_ticks(249);
        chk("alarm_499", alarm, 0);
        run_ticks(1);
        chk("alarm_500", alarm, 32'(ALARM_ON));
        do_load(4'd0, 4'd0, 4'd1);
        chk("reload_alarm", alarm, 0);
        chk("reload_done", done, 0);
        chk("reload_digs", digs, 24'h001000);

        @(negedge clk);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
